// File: rtl/boot_loader_if.sv
// UART byte stream into the loader and word-write port out to core flash.
interface boot_loader_if #(
  parameter int WIDTH = 32
) ();
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic [WIDTH-1:0] flash_addr;
  logic [WIDTH-1:0] flash_data;
  logic             flash_en;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, flash_addr, flash_data, flash_en
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, flash_addr, flash_data, flash_en
  );
endinterface

// File: rtl/boot_loader.sv
// Frame parser: SYNC, count, base, words, checksum; each word is written one cycle after its last byte.
// Backpressure: rx_ready drops only during the single WRITE cycle; the core is held in reset until the checksum passes.
module boot_loader #(
  parameter int         WIDTH   = 32,
  parameter logic [7:0] SYNC    = 8'hB0,
  parameter int         TIMEOUT = 100000
) (
  input  logic          clk,
  input  logic          rst,
  boot_loader_if.slave  bus,
  output logic          core_rst,
  output logic          done,
  output logic          err
);

  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] TMAX = IW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, CNT, ADDR, DATA, WRITE, CHECK, DONE, ERROR
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       byte_cnt;
  logic [15:0]      word_cnt;
  logic [15:0]      cnt_n;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] word_nxt;
  logic [7:0]       csum;
  logic [IW-1:0]    idle_cnt;
  logic [WIDTH-1:0] flash_addr_q;
  logic [WIDTH-1:0] flash_data_q;
  logic             rx_rdy;
  logic             acc;
  logic             in_frame;

  assign bus.flash_addr = flash_addr_q;
  assign bus.flash_data = flash_data_q;
  assign bus.rx_ready   = rx_rdy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rx_rdy    = (state != WRITE);
    acc       = bus.rx_valid && rx_rdy;
    in_frame  = (state == CNT) || (state == ADDR) || (state == DATA) ||
                (state == WRITE) || (state == CHECK);
    bus.flash_en = (state == WRITE);
    core_rst  = (state != DONE);
    done      = (state == DONE);
    err       = (state == ERROR);
    word_nxt  = word;
    word_nxt[{byte_cnt, 3'b000} +: 8] = bus.rx_data;

    case (state)
      IDLE, ERROR: if (acc && bus.rx_data == SYNC) state_nxt = CNT;
      CNT:   if (acc && byte_cnt == 2'd1) state_nxt = ADDR;
      ADDR:  if (acc && byte_cnt == 2'd3) state_nxt = (cnt_n == 16'd0) ? CHECK : DATA;
      DATA:  if (acc && byte_cnt == 2'd3) state_nxt = WRITE;
      WRITE: state_nxt = (word_cnt == cnt_n - 16'd1) ? CHECK : DATA;
      CHECK: if (acc) state_nxt = (bus.rx_data == csum) ? DONE : ERROR;
      default: state_nxt = state;
    endcase

    // An idle gap inside a frame aborts it, whatever the state was about to do.
    if (in_frame && !acc && idle_cnt == TMAX) state_nxt = ERROR;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_cnt     <= '0;
      word_cnt     <= '0;
      cnt_n        <= '0;
      base         <= '0;
      word         <= '0;
      csum         <= '0;
      idle_cnt     <= '0;
      flash_addr_q <= '0;
      flash_data_q <= '0;
    end else begin
      idle_cnt <= (in_frame && !acc) ? idle_cnt + IW'(1) : '0;
      if (acc) begin
        case (state)
          IDLE, ERROR: if (bus.rx_data == SYNC) begin
            csum     <= '0;
            byte_cnt <= '0;
            word_cnt <= '0;
          end
          CNT: begin
            cnt_n[{byte_cnt[0], 3'b000} +: 8] <= bus.rx_data;
            csum     <= csum + bus.rx_data;
            byte_cnt <= byte_cnt[0] ? 2'd0 : byte_cnt + 2'd1;
          end
          ADDR: begin
            base[{byte_cnt, 3'b000} +: 8] <= bus.rx_data;
            csum     <= csum + bus.rx_data;
            byte_cnt <= byte_cnt + 2'd1;
          end
          DATA: begin
            word     <= word_nxt;
            csum     <= csum + bus.rx_data;
            byte_cnt <= byte_cnt + 2'd1;
            // Latch address and data only once the word is complete.
            if (byte_cnt == 2'd3) begin
              flash_addr_q <= base + WIDTH'({word_cnt, 2'b00});
              flash_data_q <= word_nxt;
            end
          end
          default: ;
        endcase
      end
      if (state == WRITE) word_cnt <= word_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: table of frames plus timeout and mid-frame reset sequences.
module tb_boot_loader;
  localparam int W  = 32;
  localparam int TO = 20;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic core_rst, done, err;

  boot_loader_if #(.WIDTH(W)) bus ();

  boot_loader #(.WIDTH(W), .SYNC(8'hB0), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .core_rst(core_rst), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int wr_seen = 0;

  typedef struct packed {
    logic [W-1:0] addr;
    logic [W-1:0] data;
  } wr_t;
  wr_t exp_q[$];
  wr_t mon_e;

  typedef struct {
    bit          do_rst;
    bit          garbage;
    logic [15:0] n;
    logic [31:0] base;
    logic [31:0] w0, w1, w2;
    logic [7:0]  cs_xor;
    bit          exp_done;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every strobe pops the oldest expected write.
  always @(negedge clk) begin
    if (rst && bus.flash_en === 1'b1) begin
      wr_seen++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %0h data %0h want no write", bus.flash_addr, bus.flash_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", bus.flash_addr, mon_e.addr);
        chk("wr_data", bus.flash_data, mon_e.data);
        chk("wr_rx_ready", bus.rx_ready, 0);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (!bus.rx_ready && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.rx_ready) chk("rx_ready_wait", bus.rx_ready, 1);
    @(posedge clk);
    #1 bus.rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic send_frame(input vec_t v);
    logic [7:0]  q[$];
    logic [7:0]  cs;
    logic [31:0] ws[3];
    wr_t         e;
    ws[0] = v.w0; ws[1] = v.w1; ws[2] = v.w2;
    cs = 8'h00;
    if (v.garbage) begin
      q.push_back(8'h00); q.push_back(8'hFF); q.push_back(8'h13);
    end
    q.push_back(8'hB0);
    for (int j = 0; j < 2; j++) begin
      q.push_back(v.n[8*j +: 8]); cs = cs + v.n[8*j +: 8];
    end
    for (int j = 0; j < 4; j++) begin
      q.push_back(v.base[8*j +: 8]); cs = cs + v.base[8*j +: 8];
    end
    for (int k = 0; k < int'(v.n); k++) begin
      for (int j = 0; j < 4; j++) begin
        q.push_back(ws[k][8*j +: 8]); cs = cs + ws[k][8*j +: 8];
      end
      e.addr = v.base + 32'(4 * k);
      e.data = ws[k];
      exp_q.push_back(e);
    end
    q.push_back(cs ^ v.cs_xor);
    foreach (q[i]) send_byte(q[i]);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rx_ready"}, bus.rx_ready, 1);
    chk({tag, "_flash_en"}, bus.flash_en, 0);
    chk({tag, "_flash_addr"}, bus.flash_addr, 0);
    chk({tag, "_flash_data"}, bus.flash_data, 0);
    chk({tag, "_core_rst"}, core_rst, 1);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[6];
    logic [7:0] bq[$];
    int wr_before;

    vecs[0] = '{1'b1, 1'b0, 16'd2, 32'h0000_0024, 32'h1, 32'h1, 32'h0, 8'h00, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 16'd2, 32'h0000_0024, 32'h1, 32'h1, 32'h0, 8'h01, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 16'd2, 32'h0000_0024, 32'h1, 32'h1, 32'h0, 8'h00, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 16'd0, 32'h0000_0000, 32'h0, 32'h0, 32'h0, 8'h00, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 16'd2, 32'hFFFF_FFFC, 32'hA5A5_5A5A, 32'h1234_5678, 32'h0, 8'h00, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 16'd3, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0BAD_F00D, 32'h00C0_FFEE, 8'h00, 1'b1};

    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b1;

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].do_rst) do_reset();
      send_frame(vecs[i]);
      repeat (4) @(negedge clk);
      chk($sformatf("v%0d_done", i), done, vecs[i].exp_done);
      chk($sformatf("v%0d_err", i), err, !vecs[i].exp_done);
      chk($sformatf("v%0d_core_rst", i), core_rst, !vecs[i].exp_done);
      chk($sformatf("v%0d_pending_writes", i), exp_q.size(), 0);
    end

    // Stall after two bytes of the first data word.
    do_reset();
    wr_before = wr_seen;
    bq = '{8'hB0, 8'h02, 8'h00, 8'h24, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00};
    foreach (bq[i]) send_byte(bq[i]);
    repeat (TO - 1) @(posedge clk);
    #1 chk("timeout_err_early", err, 0);
    @(posedge clk);
    #1 chk("timeout_err", err, 1);
    chk("timeout_core_rst", core_rst, 1);
    chk("timeout_no_write", wr_seen, wr_before);

    // Reset asserted after the sixth byte of a frame.
    do_reset();
    bq = '{8'hB0, 8'h02, 8'h00, 8'h24, 8'h00, 8'h00};
    foreach (bq[i]) send_byte(bq[i]);
    @(negedge clk);
    rst = 1'b0;
    #1 chk_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b1;
    send_frame(vecs[0]);
    repeat (4) @(negedge clk);
    chk("midrst_resend_done", done, 1);
    chk("midrst_resend_err", err, 0);
    chk("midrst_pending_writes", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/boot_loader.md
BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001: Parameter WIDTH, default 32, sets the flash address and flash data width.
REQ-002: Parameter SYNC, default 8'hB0, is the frame start byte.
REQ-003: Parameter TIMEOUT, default 100000, is the maximum number of idle cycles allowed between bytes inside a frame.
REQ-004: clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005: rst  in  1  asynchronous, active-low reset.
REQ-006: rx_data  in  8  byte from the UART receiver.
REQ-007: rx_valid  in  1  rx_data is valid.
REQ-008: rx_ready  out  1  loader can accept a byte; a byte transfers when rx_valid and rx_ready are both 1 on a clk edge.
REQ-009: flash_addr  out  WIDTH  byte address of the word being written to core memory.
REQ-010: flash_data  out  WIDTH  word being written to core memory.
REQ-011: flash_en  out  1  one-cycle write strobe to the core's flash port.
REQ-012: core_rst  out  1  active-high reset to the core; held at 1 while loading.
REQ-013: done  out  1  frame loaded and checksum verified.
REQ-014: err  out  1  checksum failure or inter-byte timeout.

Function
REQ-015: Frame byte order SHALL be: SYNC; word count N, 16-bit little-endian; base address, 4 bytes little-endian; N data words, 4 bytes each little-endian; 1 checksum byte.
REQ-016: FSM states SHALL be IDLE, CNT (2 bytes), ADDR (4 bytes), DATA, WRITE, CHECK, DONE and ERROR.
REQ-017: In IDLE, non-SYNC bytes SHALL be accepted and discarded; a SYNC byte SHALL clear the checksum and byte counters and move the FSM to CNT.
REQ-018: After the 4th ADDR byte, the FSM SHALL go to CHECK if N==0, otherwise to DATA.
REQ-019: After the 4th byte of a word is accepted, the FSM SHALL enter WRITE for exactly one cycle.
REQ-020: In WRITE: flash_en=1, flash_addr = base + 4*k (k = word index from 0), flash_data = the assembled word.
REQ-021: After WRITE the FSM SHALL return to DATA, or go to CHECK after word N-1.
REQ-022: rx_ready SHALL be 0 in WRITE and 1 in every other state.
REQ-023: flash_addr and flash_data SHALL hold their values after the strobe until the next WRITE.
REQ-024: Address arithmetic SHALL be modulo 2^WIDTH; 32'hFFFFFFFC + 4 wraps to 0.
REQ-025: Checksum SHALL be the 8-bit sum, modulo 256, of every byte after SYNC and before the checksum byte.
REQ-026: In CHECK, a matching checksum byte SHALL move the FSM to DONE; a mismatching byte SHALL move it to ERROR.
REQ-027: DONE SHALL set done=1 and core_rst=0, and SHALL accept and ignore all further bytes until reset.
REQ-028: ERROR SHALL set err=1 and core_rst=1.
REQ-029: In ERROR, a SYNC byte SHALL clear err and restart the frame in CNT; all other bytes SHALL be discarded.
REQ-030: Words SHALL be written as they arrive, before the checksum is verified; the core stays in reset on error, so no rollback is needed.
REQ-031: In CNT, ADDR, DATA and CHECK, an idle counter SHALL reset on each accepted byte; reaching TIMEOUT cycles SHALL move the FSM to ERROR. The counter SHALL be inactive in IDLE, DONE and ERROR.
REQ-032: A partially received word SHALL never be written.

Reset
REQ-033: While rst==0: FSM=IDLE, rx_ready=1, flash_en=0, flash_addr=0, flash_data=0, core_rst=1, done=0, err=0, and all counters and the checksum = 0.
REQ-034: Reset asserted mid-frame SHALL abort the frame immediately with no further flash_en.
REQ-035: After reset releases, the FSM SHALL wait in IDLE for SYNC.

Verification
REQ-036: Stream B0 02 00 24 00 00 00 01 00 00 00 01 00 00 00 28 -> two flash_en pulses (0x24/0x1, then 0x28/0x1); then done=1, core_rst=0, err=0.
REQ-037: Same frame with checksum 0x29 -> err=1, core_rst=1, done=0; then resend the correct frame -> err=0, done=1.
REQ-038: Bytes 00 FF 13 before a valid N=0 frame (B0 00 00 00 00 00 00 00) -> garbage ignored, no flash_en, done=1.
REQ-039: N=2, base FC FF FF FF, correct checksum -> writes at 0xFFFFFFFC then 0x00000000.
REQ-040: Stop sending after the 2nd byte of a data word -> err=1 exactly TIMEOUT cycles after the last byte, and no flash_en for that partial word.
REQ-041: Assert rst after the 6th byte of the REQ-036 frame -> all outputs return to reset values; a full resend then completes with done=1.
